// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a byte stream into 512-bit blocks and appends 0x80, zero fill and the 64-bit bit length.
// Defining SHA1_PADDER_OVF_EN adds a sticky byte-counter overflow flag (ovf).
module sha1_padder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last
`ifdef SHA1_PADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  typedef enum logic [1:0] {FILL, PAD, ZERO, EMIT} state_e;

  state_e           state_q, state_d;
  logic [5:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic             zero_q, zero_d;
  logic             newMsg_q, newMsg_d;
  logic             last_q, last_d;
  logic [511:0]     buf_q, buf_d;
  logic [63:0]      bitLen;
  logic [8:0]       wrBase;

  assign bitLen = 64'(count_q) << 3;
  assign wrBase = 9'd511 - {ptr_q, 3'b000};

  // newMsg_q starts high so the first block after reset is flagged as first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      ptr_q    <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      zero_q   <= 1'b0;
      newMsg_q <= 1'b1;
      last_q   <= 1'b0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      zero_q   <= zero_d;
      newMsg_q <= newMsg_d;
      last_q   <= last_d;
      buf_q    <= buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    pend_d   = pend_q;
    zero_d   = zero_q;
    newMsg_d = newMsg_q;
    last_d   = last_q;
    buf_d    = buf_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          buf_d[wrBase -: 8] = in_data;
          ptr_d   = ptr_q + 6'd1;
          count_d = count_q + LEN_W'(1);
          if (ptr_q == 6'd63) begin
            state_d = EMIT;
            last_d  = 1'b0;
            pend_d  = in_last;
          end else if (in_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        for (int i = 0; i < 64; i++) begin
          if (6'(i) == ptr_q) buf_d[511-8*i -: 8] = 8'h80;
          else if (6'(i) > ptr_q) buf_d[511-8*i -: 8] = 8'h00;
        end
        // Length only fits when the marker landed in bytes 0..55; otherwise a ZERO block carries it.
        if (ptr_q <= 6'd55) begin
          buf_d[63:0] = bitLen;
          last_d      = 1'b1;
        end else begin
          last_d = 1'b0;
          zero_d = 1'b1;
        end
        state_d = EMIT;
      end
      ZERO: begin
        buf_d[511:64] = '0;
        buf_d[63:0]   = bitLen;
        last_d        = 1'b1;
        zero_d        = 1'b0;
        state_d       = EMIT;
      end
      EMIT: begin
        if (blk_ready) begin
          ptr_d = '0;
          if (last_q) begin
            state_d  = FILL;
            count_d  = '0;
            pend_d   = 1'b0;
            last_d   = 1'b0;
            newMsg_d = 1'b1;
          end else begin
            newMsg_d = 1'b0;
            if (pend_q) begin
              state_d = PAD;
              pend_d  = 1'b0;
            end else if (zero_q) begin
              state_d = ZERO;
            end else begin
              state_d = FILL;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FILL);
    blk_valid = (state_q == EMIT);
    blk_first = (state_q == EMIT) && newMsg_q;
    blk_last  = (state_q == EMIT) && last_q;
    blk_data  = buf_q;
  end

`ifdef SHA1_PADDER_OVF_EN
  logic ovf_q;

  // The first byte of a message is the only accepted byte seen with newMsg_q set and ptr at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == FILL && in_valid) begin
      if (count_q == '1) ovf_q <= 1'b1;
      else if (newMsg_q && ptr_q == 6'd0) ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: a queue-based padding model scored on every block transfer,
// plus literal checks of known padded blocks, latency, backpressure, reset and (with SHA1_PADDER_OVF_EN) overflow.
module tb_sha1_padder;

`ifdef SHA1_PADDER_OVF_EN
  localparam int LEN_W = 8;
`else
  localparam int LEN_W = 32;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic         blk_first;
  logic         blk_last;
`ifdef SHA1_PADDER_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;
  bit throttle = 1'b0;
  bit readyManual = 1'b1;

  logic [511:0] expData[$];
  bit           expFirst[$];
  bit           expLast[$];
  logic [511:0] capData[$];
  bit           capFirst[$];
  bit           capLast[$];

  localparam logic [511:0] ABC_BLK = {32'h61626380, {52{8'h00}}, 64'h18};

  sha1_padder #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_last  (blk_last)
`ifdef SHA1_PADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    blk_ready = throttle ? 1'($urandom_range(0, 1)) : readyManual;
  end

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byteOf(input int kind, input int i);
    case (kind)
      0:       return 8'h00;
      1:       return 8'(i * 7 + 3);
      default: return 8'(8'h61 + i);
    endcase
  endfunction

  // Padding model: message, 0x80, zeros to 56 mod 64, then the 64-bit big-endian bit length.
  task automatic modelMessage(input int n, input int kind);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int nb;
    for (int i = 0; i < n; i++) p.push_back(byteOf(kind, i));
    bits = (64'(n) & ((64'd1 << LEN_W) - 64'd1)) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      expData.push_back(blk);
      expFirst.push_back(b == 0);
      expLast.push_back(b == nb - 1);
    end
  endtask

  // Scoreboard: every transfer is scored against the model and captured for literal checks.
  always @(negedge clk) begin
    if (!reset && blk_valid && blk_ready) begin
      if (expData.size() == 0) begin
        checkBit("unexpected_block", 1'b1, 1'b0);
      end else begin
        checkOutput("blk_data", blk_data, expData.pop_front());
        checkBit("blk_first", blk_first, expFirst.pop_front());
        checkBit("blk_last", blk_last, expLast.pop_front());
      end
      capData.push_back(blk_data);
      capFirst.push_back(blk_first);
      capLast.push_back(blk_last);
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic last);
    int guard = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkBit("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input int kind);
    modelMessage(n, kind);
    for (int i = 0; i < n; i++) sendByte(byteOf(kind, i), i == n - 1);
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expData.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkBit("drain_complete", expData.size() == 0, 1'b1);
    @(posedge clk);
    #2;
  endtask

  task automatic clearCapture();
    capData.delete();
    capFirst.delete();
    capLast.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    checkBit("reset_blk_valid", blk_valid, 1'b0);
    checkOutput("reset_blk_data", blk_data, 512'h0);
`ifdef SHA1_PADDER_OVF_EN
    checkBit("reset_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkBit("reset_in_ready", in_ready, 1'b1);

    // "abc" with blk_ready held low: latency, stability and release.
    readyManual = 1'b0;
    @(posedge clk);
    #2;
    clearCapture();
    modelMessage(3, 2);
    sendByte(8'h61, 1'b0);
    sendByte(8'h62, 1'b0);
    sendByte(8'h63, 1'b1);
    checkBit("latency_pad_cycle", blk_valid, 1'b0);
    @(posedge clk);
    #1;
    checkBit("latency_last_byte", blk_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_blk_data", blk_data, ABC_BLK);
      checkBit("stall_in_ready", in_ready, 1'b0);
      checkBit("stall_blk_valid", blk_valid, 1'b1);
    end
    readyManual = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    checkBit("stall_release", blk_valid, 1'b0);
    checkOutput("abc_count", 512'(capData.size()), 512'd1);
    checkOutput("abc_literal", capData[0], ABC_BLK);
    checkBit("abc_first", capFirst[0], 1'b1);
    checkBit("abc_last", capLast[0], 1'b1);

    clearCapture();
    applyStimulus(55, 0);
    waitDrain();
    checkOutput("len55_count", 512'(capData.size()), 512'd1);
    checkOutput("len55_literal", capData[0], {{55{8'h00}}, 8'h80, 64'h1B8});
    checkBit("len55_last", capLast[0], 1'b1);

    clearCapture();
    applyStimulus(56, 0);
    waitDrain();
    checkOutput("len56_count", 512'(capData.size()), 512'd2);
    checkOutput("len56_blk1", capData[0], {{56{8'h00}}, 8'h80, {7{8'h00}}});
    checkBit("len56_blk1_last", capLast[0], 1'b0);
    checkOutput("len56_blk2", capData[1], {{56{8'h00}}, 64'h1C0});
    checkBit("len56_blk2_first", capFirst[1], 1'b0);
    checkBit("len56_blk2_last", capLast[1], 1'b1);

    clearCapture();
    modelMessage(64, 0);
    for (int i = 0; i < 64; i++) sendByte(8'h00, i == 63);
    checkBit("latency_full_block", blk_valid, 1'b1);
    waitDrain();
    checkOutput("len64_count", 512'(capData.size()), 512'd2);
    checkBit("len64_blk1_last", capLast[0], 1'b0);
    checkOutput("len64_blk2", capData[1], {8'h80, {55{8'h00}}, 64'h200});

    // Random backpressure over lengths around the block boundaries.
    throttle = 1'b1;
    applyStimulus(1, 1);
    applyStimulus(119, 1);
    applyStimulus(120, 1);
    applyStimulus(128, 1);
    applyStimulus(200, 1);
    waitDrain();
    throttle = 1'b0;
    @(posedge clk);
    #2;

    // Reset mid-message discards the partial block.
    for (int i = 0; i < 10; i++) sendByte(byteOf(1, i), 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkBit("midreset_in_ready", in_ready, 1'b1);
    checkBit("midreset_blk_valid", blk_valid, 1'b0);
    clearCapture();
    applyStimulus(3, 2);
    waitDrain();
    checkOutput("midreset_abc", capData[0], ABC_BLK);
    checkBit("midreset_first", capFirst[0], 1'b1);

`ifdef SHA1_PADDER_OVF_EN
    modelMessage(256, 1);
    for (int i = 0; i < 256; i++) begin
      sendByte(byteOf(1, i), i == 255);
      if (i == 254) checkBit("ovf_before_wrap", ovf, 1'b0);
    end
    checkBit("ovf_after_256", ovf, 1'b1);
    waitDrain();
    checkBit("ovf_sticky", ovf, 1'b1);
    modelMessage(3, 2);
    sendByte(8'h61, 1'b0);
    checkBit("ovf_cleared_next_msg", ovf, 1'b0);
    sendByte(8'h62, 1'b0);
    sendByte(8'h63, 1'b1);
    waitDrain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
